// File: rtl/sgm_pkg.sv
// Shared defaults, helpers and latency constant for the SGM aggregation blocks.
package sgm_pkg;

    localparam int SGM_DISP_RANGE = 4;
    localparam int SGM_COST_WIDTH = 6;
    localparam int SGM_ACC_WIDTH  = 8;
    localparam int SGM_P1         = 2;
    localparam int SGM_P2         = 8;

    // Register stages between cost_in/prev_in and agg_out; the row delay is sized from it.
    localparam int AGG_LATENCY    = 3;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sgm_min_tree.sv
// Combinational minimum of N packed W-bit elements, built as a balanced binary tree.
module sgm_min_tree
    import sgm_pkg::*;
#(
    parameter int N = SGM_DISP_RANGE,
    parameter int W = SGM_ACC_WIDTH
) (
    input  logic [N*W-1:0] vec,
    output logic [W-1:0]   min_out
);

    localparam int LEVELS = clog2(N);
    localparam int NP     = 1 << LEVELS;

    // Heap layout: node 1 is the root, leaves occupy NP..2*NP-1; padding leaves never win.
    logic [W-1:0] node [1:2*NP-1];

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi = gi + 1) begin : g_leaf
            if (gi < N) begin : g_real
                assign node[NP+gi] = vec[gi*W +: W];
            end else begin : g_pad
                assign node[NP+gi] = '1;
            end
        end
        for (gi = 1; gi < NP; gi = gi + 1) begin : g_node
            assign node[gi] = (node[2*gi] < node[2*gi+1]) ? node[2*gi] : node[2*gi+1];
        end
    endgenerate

    assign min_out = node[1];

endmodule

// File: rtl/sgm_vertical_aggregator.sv
// SGM top-to-bottom path cost L(p,d), one pixel per ce, three ce-gated pipeline stages.
// Define SGM_AGG_SATURATE_EN to clamp the result instead of wrapping it.
module sgm_vertical_aggregator
    import sgm_pkg::*;
#(
    parameter int DISP_RANGE  = SGM_DISP_RANGE,
    parameter int COST_WIDTH  = SGM_COST_WIDTH,
    parameter int ACC_WIDTH   = SGM_ACC_WIDTH,
    parameter int P1          = SGM_P1,
    parameter int P2          = SGM_P2,
    parameter int IMAGE_WIDTH = 640
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ce,
    input  logic                            frame_start,
    input  logic [DISP_RANGE*COST_WIDTH-1:0] cost_in,
    input  logic [DISP_RANGE*ACC_WIDTH-1:0]  prev_in,
    output logic [DISP_RANGE*ACC_WIDTH-1:0]  agg_out,
    output logic                            out_valid
);

    localparam int SUM_W = ACC_WIDTH + 2;
    localparam int COL_W = (clog2(IMAGE_WIDTH) < 1) ? 1 : clog2(IMAGE_WIDTH);

    logic [COL_W-1:0] col_reg, col_next, pix_col;
    logic             first_row_reg, first_row_next, pix_first_row;

    logic [DISP_RANGE*COST_WIDTH-1:0] s1_cost_reg, s2_cost_reg;
    logic [DISP_RANGE*ACC_WIDTH-1:0]  s1_prev_reg;
    logic [ACC_WIDTH-1:0]             s1_min_reg, s2_min_reg, prev_min;
    logic                             s1_first_row_reg, s2_first_row_reg;
    logic [DISP_RANGE*SUM_W-1:0]      s2_cand_reg, cand_next;
    logic [DISP_RANGE*ACC_WIDTH-1:0]  agg_reg, agg_next;
    logic [AGG_LATENCY-1:0]           valid_sr_reg;

    // frame_start overrides the running counter for the pixel it arrives with.
    always_comb begin
        pix_col       = frame_start ? '0 : col_reg;
        pix_first_row = frame_start | first_row_reg;
        col_next      = pix_col + COL_W'(1);
        first_row_next = pix_first_row;
        if (pix_col == COL_W'(IMAGE_WIDTH - 1)) begin
            col_next       = '0;
            first_row_next = 1'b0;
        end
    end

    sgm_min_tree #(
        .N (DISP_RANGE),
        .W (ACC_WIDTH)
    ) u_min_tree (
        .vec     (prev_in),
        .min_out (prev_min)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DISP_RANGE; gi = gi + 1) begin : g_cand
            logic [SUM_W-1:0] self_c, left_c, right_c, far_c, lr_min, sf_min;

            assign self_c = SUM_W'(s1_prev_reg[gi*ACC_WIDTH +: ACC_WIDTH]);
            assign far_c  = SUM_W'(s1_min_reg) + SUM_W'(P2);

            // Missing neighbours at the disparity edges are replaced by an unbeatable value.
            if (gi > 0) begin : g_left
                assign left_c = SUM_W'(s1_prev_reg[(gi-1)*ACC_WIDTH +: ACC_WIDTH]) + SUM_W'(P1);
            end else begin : g_no_left
                assign left_c = '1;
            end
            if (gi < DISP_RANGE - 1) begin : g_right
                assign right_c = SUM_W'(s1_prev_reg[(gi+1)*ACC_WIDTH +: ACC_WIDTH]) + SUM_W'(P1);
            end else begin : g_no_right
                assign right_c = '1;
            end

            assign lr_min = (left_c < right_c) ? left_c : right_c;
            assign sf_min = (self_c < far_c) ? self_c : far_c;
            assign cand_next[gi*SUM_W +: SUM_W] = (lr_min < sf_min) ? lr_min : sf_min;
        end

        for (gi = 0; gi < DISP_RANGE; gi = gi + 1) begin : g_out
            logic [SUM_W-1:0] c_ext, m_ext, cand;

            assign c_ext = SUM_W'(s2_cost_reg[gi*COST_WIDTH +: COST_WIDTH]);
            assign m_ext = SUM_W'(s2_min_reg);
            assign cand  = s2_cand_reg[gi*SUM_W +: SUM_W];

`ifdef SGM_AGG_SATURATE_EN
            logic [SUM_W-1:0] full;
            // cand >= m always, so the subtraction cannot underflow.
            assign full = s2_first_row_reg ? c_ext : (c_ext + cand - m_ext);
            assign agg_next[gi*ACC_WIDTH +: ACC_WIDTH] =
                (full > SUM_W'({ACC_WIDTH{1'b1}})) ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
`else
            assign agg_next[gi*ACC_WIDTH +: ACC_WIDTH] =
                s2_first_row_reg ? ACC_WIDTH'(c_ext) : ACC_WIDTH'(c_ext + cand - m_ext);
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_reg          <= '0;
            first_row_reg    <= 1'b1;
            s1_cost_reg      <= '0;
            s1_prev_reg      <= '0;
            s1_min_reg       <= '0;
            s1_first_row_reg <= 1'b0;
            s2_cost_reg      <= '0;
            s2_cand_reg      <= '0;
            s2_min_reg       <= '0;
            s2_first_row_reg <= 1'b0;
            agg_reg          <= '0;
            valid_sr_reg     <= '0;
        end else if (ce) begin
            col_reg          <= col_next;
            first_row_reg    <= first_row_next;
            s1_cost_reg      <= cost_in;
            s1_prev_reg      <= prev_in;
            s1_min_reg       <= prev_min;
            s1_first_row_reg <= pix_first_row;
            s2_cost_reg      <= s1_cost_reg;
            s2_cand_reg      <= cand_next;
            s2_min_reg       <= s1_min_reg;
            s2_first_row_reg <= s1_first_row_reg;
            agg_reg          <= agg_next;
            valid_sr_reg     <= {valid_sr_reg[AGG_LATENCY-2:0], 1'b1};
        end
    end

    assign agg_out   = agg_reg;
    assign out_valid = valid_sr_reg[AGG_LATENCY-1];

endmodule

// File: tb/tb_sgm_vertical_aggregator.sv
// Self-checking bench: vector table, model-checked random stream, and directed corner sequences.
module tb_sgm_vertical_aggregator;

    localparam int D   = 4;
    localparam int CW  = 6;
    localparam int AW  = 8;
    localparam int AW6 = 6;
    localparam int IW  = 4;
    localparam int P1  = 2;
    localparam int P2  = 8;
    localparam int NV  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b0;
    logic frame_start = 1'b0;
    logic [D*CW-1:0]  cost_in = '0;
    logic [D*AW-1:0]  prev_in = '0;
    logic [D*AW6-1:0] prev6_in = '0;
    logic [D*AW-1:0]  agg_out;
    logic             out_valid;
    logic [D*AW6-1:0] agg6_out;
    logic             out6_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sgm_vertical_aggregator #(
        .DISP_RANGE(D), .COST_WIDTH(CW), .ACC_WIDTH(AW),
        .P1(P1), .P2(P2), .IMAGE_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .frame_start(frame_start),
        .cost_in(cost_in), .prev_in(prev_in),
        .agg_out(agg_out), .out_valid(out_valid)
    );

    sgm_vertical_aggregator #(
        .DISP_RANGE(D), .COST_WIDTH(CW), .ACC_WIDTH(AW6),
        .P1(P1), .P2(P2), .IMAGE_WIDTH(IW)
    ) dut6 (
        .clk(clk), .rst(rst), .ce(ce), .frame_start(frame_start),
        .cost_in(cost_in), .prev_in(prev6_in),
        .agg_out(agg6_out), .out_valid(out6_valid)
    );

    function automatic logic [D*CW-1:0] pc(input int a, input int b, input int c, input int e);
        return {CW'(e), CW'(c), CW'(b), CW'(a)};
    endfunction

    function automatic logic [D*AW-1:0] pa(input int a, input int b, input int c, input int e);
        return {AW'(e), AW'(c), AW'(b), AW'(a)};
    endfunction

    // Reference: straight from the path-cost formula, per disparity.
    function automatic logic [D*AW-1:0] ref_l(input logic [D*CW-1:0] c, input logic [D*AW-1:0] p,
                                              input bit fr);
        int cv[D];
        int pv[D];
        int m, best, l;
        logic [D*AW-1:0] r;
        for (int d = 0; d < D; d++) begin
            cv[d] = int'(c[d*CW +: CW]);
            pv[d] = int'(p[d*AW +: AW]);
        end
        m = pv[0];
        for (int d = 1; d < D; d++) if (pv[d] < m) m = pv[d];
        r = '0;
        for (int d = 0; d < D; d++) begin
            if (fr) begin
                l = cv[d];
            end else begin
                best = m + P2;
                if (pv[d] < best) best = pv[d];
                if (d > 0 && pv[d-1] + P1 < best) best = pv[d-1] + P1;
                if (d < D - 1 && pv[d+1] + P1 < best) best = pv[d+1] + P1;
                l = cv[d] + best - m;
            end
            r[d*AW +: AW] = AW'(l);
        end
        return r;
    endfunction

    int m_col = 0;
    int m_fr = 1;
    int acc_cnt = 0;
    int pix_no = 0;
    logic [D*AW-1:0] exp_q[$];

    task automatic model_reset();
        m_col = 0;
        m_fr = 1;
        acc_cnt = 0;
        exp_q.delete();
    endtask

    task automatic check_out(input string name);
        logic [D*AW-1:0] e;
        logic ev;
        ev = (acc_cnt >= 3);
        e = ev ? exp_q[acc_cnt-3] : '0;
        checks++;
        if (agg_out !== e) begin
            errors++;
            $display("FAIL %s agg_out got %h expected %h", name, agg_out, e);
        end
        checks++;
        if (out_valid !== ev) begin
            errors++;
            $display("FAIL %s out_valid got %b expected %b", name, out_valid, ev);
        end
    endtask

    task automatic pixel(input logic fs, input logic [D*CW-1:0] c, input logic [D*AW-1:0] p,
                         input string name);
        frame_start = fs;
        cost_in = c;
        prev_in = p;
        for (int d = 0; d < D; d++) prev6_in[d*AW6 +: AW6] = p[d*AW +: AW6];
        ce = 1'b1;
        if (fs) begin
            m_col = 0;
            m_fr = 1;
        end
        exp_q.push_back(ref_l(c, p, m_fr[0]));
        m_col++;
        if (m_col == IW) begin
            m_col = 0;
            m_fr = 0;
        end
        @(posedge clk);
        #1;
        acc_cnt++;
        ce = 1'b0;
        frame_start = 1'b0;
        check_out(name);
        $display("pix %0d %s fs=%b cost=%h prev=%h agg=%h valid=%b", pix_no, name, fs, c, p,
                 agg_out, out_valid);
        pix_no++;
    endtask

    task automatic idle(input int n);
        ce = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check_out("stall");
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_out("reset_async");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic            fs;
        logic [D*CW-1:0] cost;
        logic [D*AW-1:0] prev;
        logic [D*AW-1:0] exp;
    } vec_t;

    vec_t tbl[NV];

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D*CW-1:0] rc;
        logic [D*AW-1:0] rp;
        logic            rfs;
        logic [D*AW-1:0] held;

        tbl[0] = '{1'b1, pc(5, 3, 7, 1),     pa(200, 0, 0, 0),  pa(5, 3, 7, 1)};
        tbl[1] = '{1'b0, pc(1, 2, 3, 4),     pa(9, 9, 9, 9),    pa(1, 2, 3, 4)};
        tbl[2] = '{1'b0, pc(0, 0, 0, 0),     pa(1, 2, 3, 4),    pa(0, 0, 0, 0)};
        tbl[3] = '{1'b0, pc(63, 0, 63, 0),   pa(0, 90, 0, 90),  pa(63, 0, 63, 0)};
        tbl[4] = '{1'b0, pc(1, 1, 1, 1),     pa(10, 4, 9, 6),   pa(3, 1, 3, 3)};
        tbl[5] = '{1'b0, pc(0, 0, 0, 0),     pa(0, 0, 0, 0),    pa(0, 0, 0, 0)};
        tbl[6] = '{1'b0, pc(2, 2, 2, 2),     pa(0, 50, 50, 50), pa(2, 4, 10, 10)};
        tbl[7] = '{1'b0, pc(10, 20, 30, 40), pa(7, 7, 7, 7),    pa(10, 20, 30, 40)};

        #2 rst = 1'b0;
        #1;
        model_reset();
        check_out("reset_state");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table: each record is one pixel; its output appears after the third ce.
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) begin
                frame_start = tbl[i].fs;
                cost_in = tbl[i].cost;
                prev_in = tbl[i].prev;
            end else begin
                frame_start = 1'b0;
                cost_in = '0;
                prev_in = '0;
            end
            ce = 1'b1;
            @(posedge clk);
            #1;
            ce = 1'b0;
            checks++;
            if (out_valid !== (i >= 2)) begin
                errors++;
                $display("FAIL tbl_valid%0d out_valid got %b expected %b", i, out_valid, (i >= 2));
            end
            if (i >= 2) begin
                checks++;
                if (agg_out !== tbl[i-2].exp) begin
                    errors++;
                    $display("FAIL tbl%0d agg_out got %h expected %h", i - 2, agg_out, tbl[i-2].exp);
                end
            end
            $display("tbl step %0d agg=%h valid=%b", i, agg_out, out_valid);
        end

        // Randomised stream with occasional stalls and frame restarts.
        do_reset();
        for (int i = 0; i < 160; i++) begin
            rc = {$urandom, $urandom};
            rp = {$urandom};
            rfs = (i == 0) || ($urandom_range(0, 29) == 0);
            pixel(rfs, rc, rp, "rand");
            if (i == 80) begin
                held = agg_out;
                idle(5);
                checks++;
                if (agg_out !== held) begin
                    errors++;
                    $display("FAIL stall_hold agg_out got %h expected %h", agg_out, held);
                end
            end else if ($urandom_range(0, 9) == 0) begin
                idle($urandom_range(1, 3));
            end
        end

        // Reset in the middle of a row (counter at 2), then first-row behaviour resumes at col 0.
        pixel(1'b1, pc(4, 4, 4, 4), pa(1, 2, 3, 4), "pre_rst");
        pixel(1'b0, pc(5, 6, 7, 8), pa(1, 2, 3, 4), "pre_rst");
        do_reset();
        pixel(1'b0, pc(9, 8, 7, 6), pa(0, 60, 60, 60), "post_rst");
        pixel(1'b0, pc(1, 1, 1, 1), pa(0, 60, 60, 60), "post_rst");
        pixel(1'b0, pc(1, 1, 1, 1), pa(0, 60, 60, 60), "post_rst");
        checks++;
        if (agg_out !== pa(9, 8, 7, 6)) begin
            errors++;
            $display("FAIL rst_first_row agg_out got %h expected %h", agg_out, pa(9, 8, 7, 6));
        end

        // frame_start at col 2: four pass-through pixels, the fifth uses the recurrence.
        pixel(1'b1, pc(3, 3, 3, 3), pa(5, 5, 5, 5), "fs_pre");
        pixel(1'b0, pc(3, 3, 3, 3), pa(5, 5, 5, 5), "fs_pre");
        pixel(1'b0, pc(3, 3, 3, 3), pa(5, 5, 5, 5), "fs_pre");
        pixel(1'b0, pc(3, 3, 3, 3), pa(5, 5, 5, 5), "fs_pre");
        pixel(1'b0, pc(3, 3, 3, 3), pa(5, 5, 5, 5), "fs_pre");
        pixel(1'b0, pc(3, 3, 3, 3), pa(5, 5, 5, 5), "fs_pre");
        pixel(1'b1, pc(2, 2, 2, 2), pa(0, 50, 50, 50), "fs_mid");
        for (int i = 0; i < 3; i++) pixel(1'b0, pc(2, 2, 2, 2), pa(0, 50, 50, 50), "fs_row1");
        pixel(1'b0, pc(2, 2, 2, 2), pa(0, 50, 50, 50), "fs_row2");
        pixel(1'b0, pc(0, 0, 0, 0), pa(0, 0, 0, 0), "fs_flush");
        pixel(1'b0, pc(0, 0, 0, 0), pa(0, 0, 0, 0), "fs_flush");
        checks++;
        if (agg_out !== pa(2, 4, 10, 10)) begin
            errors++;
            $display("FAIL fs_fifth agg_out got %h expected %h", agg_out, pa(2, 4, 10, 10));
        end

        // Narrow accumulator: d1 = 63 + 2 - 0 = 65 overflows 6 bits.
        do_reset();
        pixel(1'b1, pc(1, 2, 3, 4), pa(0, 0, 0, 0), "sat_row1");
        for (int i = 0; i < 3; i++) pixel(1'b0, pc(1, 2, 3, 4), pa(0, 0, 0, 0), "sat_row1");
        pixel(1'b0, pc(63, 63, 63, 63), pa(0, 20, 20, 20), "sat_row2");
        pixel(1'b0, pc(0, 0, 0, 0), pa(0, 0, 0, 0), "sat_flush");
        pixel(1'b0, pc(0, 0, 0, 0), pa(0, 0, 0, 0), "sat_flush");
        checks++;
`ifdef SGM_AGG_SATURATE_EN
        if (agg6_out[1*AW6 +: AW6] !== 6'd63) begin
            errors++;
            $display("FAIL sat_d1 agg6 got %0d expected 63", agg6_out[1*AW6 +: AW6]);
        end
`else
        if (agg6_out[1*AW6 +: AW6] !== 6'd1) begin
            errors++;
            $display("FAIL wrap_d1 agg6 got %0d expected 1", agg6_out[1*AW6 +: AW6]);
        end
`endif
        checks++;
        if (out6_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_valid out6_valid got %b expected 1", out6_valid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
